// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divide controller for DIV/DIVU in the execute stage.
// It stalls the pipeline while busy and writes HI/LO with a one-cycle strobe.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;      // dividend shifts out the top while quotient bits enter the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             neg_q, neg_r, dbz;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quo_step;

  always_comb begin
    accept    = (state == IDLE) & start & ~annul;
    a_mag     = (signed_div & a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_div & b[WIDTH-1]) ? -b : b;
    rem_shift = {rem, dvd[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs};
    fits      = ~diff[WIDTH];
    rem_step  = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_step  = {dvd[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (b == '0) ? DONE : BUSY;
      BUSY: begin
        if (annul)                  state_nxt = IDLE;
        else if (count == CW'(1))   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall        = accept | (state == BUSY);
    result_valid = (state == DONE);
    div_by_zero  = (state == DONE) & dbz;
  end

  // Sign fix-up is folded into the final BUSY step so HI/LO are ready on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      lo_out <= '0;
      hi_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd   <= a_mag;
            dvs   <= b_mag;
            rem   <= '0;
            neg_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= signed_div & a[WIDTH-1];
            dbz   <= (b == '0);
            if (b == '0) begin
              count  <= '0;
              lo_out <= '1;
              hi_out <= a;
            end else begin
              count <= CW'(WIDTH);
            end
          end
        end
        BUSY: begin
          if (!annul) begin
            dvd   <= quo_step;
            rem   <= rem_step;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              lo_out <= neg_q ? -quo_step : quo_step;
              hi_out <= neg_r ? -rem_step : rem_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: an arithmetic reference model checked every cycle,
// plus literal expectations at the documented cycles.
module tb_div_sequencer;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, signed_div, annul;
  logic [W-1:0] a, b;
  logic         stall, result_valid, div_by_zero;
  logic [W-1:0] lo_out, hi_out;

  int n_vec = 0;
  int n_bad = 0;

  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul), .stall(stall), .result_valid(result_valid),
    .lo_out(lo_out), .hi_out(hi_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference divide from plain arithmetic
  function automatic void ref_div(input logic sg, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    z = 1'b0;
    if (y == 0) begin
      q = '1; r = x; z = 1'b1;
    end else if (!sg) begin
      q = x / y; r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = x; r = '0;
    end else begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end
  endfunction

  // Model: busy cycles remaining, whether this is the result cycle, and the HI/LO contents.
  bit           m_on = 1'b0;
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
  logic         m_dbz = 1'b0, p_dbz = 1'b0;

  initial begin
    logic e_stall;
    forever begin
      @(negedge clk);
      if (m_on) begin
        e_stall = (m_left > 0) || (!m_done && start && !annul);
        chk("model stall", stall, e_stall);
        chk("model result_valid", result_valid, m_done);
        chk("model lo_out", lo_out, m_lo);
        chk("model hi_out", hi_out, m_hi);
        if (m_done) chk("model div_by_zero", div_by_zero, m_dbz);
      end
      @(posedge clk);
      if (rst) begin
        m_on = 1'b1; m_left = 0; m_done = 1'b0; m_lo = '0; m_hi = '0;
      end else if (m_on) begin
        if (m_done) m_done = 1'b0;
        else if (m_left > 0) begin
          if (annul) m_left = 0;
          else begin
            m_left--;
            if (m_left == 0) begin
              m_done = 1'b1; m_lo = p_lo; m_hi = p_hi; m_dbz = p_dbz;
            end
          end
        end else if (start && !annul) begin
          ref_div(signed_div, a, b, p_lo, p_hi, p_dbz);
          if (b == 0) begin
            m_done = 1'b1; m_lo = p_lo; m_hi = p_hi; m_dbz = p_dbz;
          end else m_left = W;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Launch one op in the current cycle (cycle 0) and check stall/strobe timing and results.
  task automatic run_op(input string nm, input logic sg, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ex_lo, input logic [W-1:0] ex_hi, input logic ex_z);
    int last;
    last = (y == 0) ? 1 : W + 1;
    start = 1'b1; signed_div = sg; a = x; b = y; annul = 1'b0;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      chk({nm, " stall"}, stall, (c < last));
      chk({nm, " result_valid"}, result_valid, (c == last));
      if (c == last) begin
        chk({nm, " lo"}, lo_out, ex_lo);
        chk({nm, " hi"}, hi_out, ex_hi);
        chk({nm, " div_by_zero"}, div_by_zero, ex_z);
      end
      next_cycle();
      start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset stall", stall, 0);
    chk("reset result_valid", result_valid, 0);
    chk("reset lo", lo_out, 0);
    chk("reset hi", hi_out, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_op("divu 100/7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
    run_op("div -7/2",      1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("div 7/-2",      1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
    run_op("div overflow",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
    run_op("div -100/-7",   1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0);
    run_op("div min/2",     1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         1'b0);
    run_op("divu max/16",   1'b0, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 32'd15,        1'b0);
    run_op("divu 3/max",    1'b0, 32'd3,         32'hFFFF_FFFF, 32'd0,         32'd3,         1'b0);
    run_op("divu 5/0",      1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1);

    // Annul in cycle 10 of a 100/7 divide, then a new op in cycle 11
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) annul = 1'b1;
      @(negedge clk);
      chk("annul busy stall", stall, 1);
      chk("annul busy result_valid", result_valid, 0);
      next_cycle();
      start = 1'b0;
      annul = 1'b0;
    end
    #1;
    chk("annul idle stall", stall, 0);
    chk("annul lo kept", lo_out, 32'hFFFF_FFFF);
    chk("annul hi kept", hi_out, 32'd5);
    start = 1'b1; signed_div = 1'b1; a = 32'd1000; b = 32'd10;
    for (int c = 0; c <= W + 2; c++) begin
      @(negedge clk);
      chk("post-annul stall", stall, (c <= W));
      chk("post-annul result_valid", result_valid, (c == W + 1));
      if (c == W + 1) begin
        chk("post-annul lo", lo_out, 32'd100);
        chk("post-annul hi", hi_out, 32'd0);
      end
      next_cycle();
      start = 1'b0;
    end

    // start together with annul in IDLE is not accepted
    start = 1'b1; annul = 1'b1; signed_div = 1'b0; a = 32'd9; b = 32'd3;
    @(negedge clk);
    chk("start+annul stall", stall, 0);
    next_cycle();
    start = 1'b0; annul = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("start+annul idle stall", stall, 0);
      chk("start+annul no result", result_valid, 0);
      next_cycle();
    end

    // Reset in cycle 20 of a divide
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    for (int c = 0; c <= 20; c++) begin
      if (c == 20) rst = 1'b1;
      @(negedge clk);
      chk("pre-reset stall", stall, 1);
      next_cycle();
      start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset stall", stall, 0);
    chk("mid reset result_valid", result_valid, 0);
    chk("mid reset lo", lo_out, 0);
    chk("mid reset hi", hi_out, 0);
    chk("mid reset div_by_zero", div_by_zero, 0);
    next_cycle();

    // start held high through DONE: re-accepted only once back in IDLE
    start = 1'b1; signed_div = 1'b1; a = 32'hFFFF_FFF9; b = 32'd0;
    @(negedge clk);
    chk("held c0 stall", stall, 1);
    next_cycle();
    @(negedge clk);
    chk("held c1 stall", stall, 0);
    chk("held c1 result_valid", result_valid, 1);
    chk("held c1 div_by_zero", div_by_zero, 1);
    chk("held c1 lo", lo_out, 32'hFFFF_FFFF);
    chk("held c1 hi", hi_out, 32'hFFFF_FFF9);
    next_cycle();
    @(negedge clk);
    chk("held c2 stall", stall, 1);
    chk("held c2 result_valid", result_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("held c3 result_valid", result_valid, 1);
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
